// File: rtl/regfile_scoreboard_if.sv
// Writeback commit channel into the register file (regfile_write_if).
// The writeback stage drives it as Client; the register file receives it as Server.
interface regfile_write_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    modport Server (input  en, addr, val);
    modport Client (output en, addr, val);
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a RAW-hazard scoreboard of per-register pending-write counters.
// Optional macro RF_WRITE_FORWARD_EN: same-cycle commit forwarding to reads and to the busy check.
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS),
    parameter int unsigned CNTW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    regfile_write_if.Server write0,
    input  logic            flush,
    input  logic [AW-1:0]   rs1Addr,
    output logic [XLEN-1:0] rs1Val,
    input  logic [AW-1:0]   rs2Addr,
    output logic [XLEN-1:0] rs2Val,
    input  logic            issueValid,
    input  logic            rs1En,
    input  logic            rs2En,
    input  logic            rdEn,
    input  logic [AW-1:0]   rdAddr,
    output logic            issueStall,
    output logic            sbUnderflow
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [XLEN-1:0] regs [NREGS];
    logic [CNTW-1:0] cnt  [NREGS];

    logic            commit;
    logic [CNTW-1:0] cnt_wr;
    logic [CNTW-1:0] cnt_rd;
    logic            decr;
    logic            underflow_hit;
    logic            issue_accept;
    logic            incr;
    logic            rd_full;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:1] incr_vec;
    logic [NREGS-1:1] decr_vec;

    // Commit-side decode
    always_comb begin
        commit        = write0.en && (write0.addr != '0);
        cnt_wr        = cnt[write0.addr];
        decr          = commit && (cnt_wr != '0);
        underflow_hit = commit && (cnt_wr == '0);
    end

    // Per-register busy; with forwarding, a last pending write committing now frees the register
    always_comb begin
        busy = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy[r] = (cnt[r] != '0);
`ifdef RF_WRITE_FORWARD_EN
            if (commit && (write0.addr == AW'(r)) && (cnt[r] == CNT_ONE)) begin
                busy[r] = 1'b0;
            end
`endif
        end
    end

    // Issue hazard check and acceptance
    always_comb begin
        cnt_rd       = cnt[rdAddr];
        rd_full      = rdEn && (rdAddr != '0) && (cnt_rd == CNT_MAX);
        issueStall   = issueValid && ((rs1En && busy[rs1Addr]) ||
                                      (rs2En && busy[rs2Addr]) ||
                                      rd_full);
        issue_accept = issueValid && !issueStall && !flush;
        incr         = issue_accept && rdEn && (rdAddr != '0);
    end

    always_comb begin
        incr_vec = '0;
        decr_vec = '0;
        for (int r = 1; r < NREGS; r++) begin
            incr_vec[r] = incr && (rdAddr == AW'(r));
            decr_vec[r] = decr && (write0.addr == AW'(r));
        end
    end

    // Combinational read ports; register 0 reads as zero
    always_comb begin
        rs1Val = regs[rs1Addr];
        rs2Val = regs[rs2Addr];
`ifdef RF_WRITE_FORWARD_EN
        if (commit && (write0.addr == rs1Addr)) begin
            rs1Val = write0.val;
        end
        if (commit && (write0.addr == rs2Addr)) begin
            rs2Val = write0.val;
        end
`endif
        if (rs1Addr == '0) begin
            rs1Val = '0;
        end
        if (rs2Addr == '0) begin
            rs2Val = '0;
        end
    end

    // Register array and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            sbUnderflow <= 1'b0;
        end else begin
            if (commit) begin
                regs[write0.addr] <= write0.val;
            end
            if (underflow_hit) begin
                sbUnderflow <= 1'b1;
            end
        end
    end

    // Pending-write counters; flush overrides any concurrent increment or decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREGS; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else begin
                    case ({incr_vec[r], decr_vec[r]})
                        2'b10:   cnt[r] <= cnt[r] + CNT_ONE;
                        2'b01:   cnt[r] <= cnt[r] - CNT_ONE;
                        default: cnt[r] <= cnt[r];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus queues expected outputs, a negedge monitor compares.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNTW  = 2;
`ifdef RF_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [AW-1:0]   rs1Addr, rs2Addr, rdAddr;
    logic [XLEN-1:0] rs1Val, rs2Val;
    logic            issueValid, rs1En, rs2En, rdEn;
    logic            issueStall, sbUnderflow;

    regfile_write_if #(.XLEN(XLEN), .AW(AW)) wif ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .write0(wif), .flush(flush),
        .rs1Addr(rs1Addr), .rs1Val(rs1Val), .rs2Addr(rs2Addr), .rs2Val(rs2Val),
        .issueValid(issueValid), .rs1En(rs1En), .rs2En(rs2En), .rdEn(rdEn),
        .rdAddr(rdAddr), .issueStall(issueStall), .sbUnderflow(sbUnderflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        bit              c1;
        logic [XLEN-1:0] e1;
        bit              c2;
        logic [XLEN-1:0] e2;
        bit              cs;
        logic            es;
        bit              cu;
        logic            eu;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void chk(string n, string f, logic [XLEN-1:0] act, logic [XLEN-1:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s.%s: got %h want %h", n, f, act, want);
    endfunction

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.c1) chk(e.name, "rs1Val", rs1Val, e.e1);
            if (e.c2) chk(e.name, "rs2Val", rs2Val, e.e2);
            if (e.cs) chk(e.name, "issueStall", XLEN'(issueStall), XLEN'(e.es));
            if (e.cu) chk(e.name, "sbUnderflow", XLEN'(sbUnderflow), XLEN'(e.eu));
        end
    end

    task automatic push_exp(string n, bit c1, logic [XLEN-1:0] e1, bit c2, logic [XLEN-1:0] e2,
                            bit cs, logic es, bit cu, logic eu);
        exp_t e;
        e.name = n; e.c1 = c1; e.e1 = e1; e.c2 = c2; e.e2 = e2;
        e.cs = cs; e.es = es; e.cu = cu; e.eu = eu;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        rs1Addr = '0; rs2Addr = '0; rdAddr = '0;
        issueValid = 1'b0; rs1En = 1'b0; rs2En = 1'b0; rdEn = 1'b0;
        wif.en = 1'b0; wif.addr = '0; wif.val = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic r1e, logic [AW-1:0] r1, logic r2e, logic [AW-1:0] r2,
                         logic rde, logic [AW-1:0] rd);
        issueValid = 1'b1; rs1En = r1e; rs1Addr = r1; rs2En = r2e; rs2Addr = r2;
        rdEn = rde; rdAddr = rd;
    endtask

    task automatic commit(logic [AW-1:0] a, logic [XLEN-1:0] v);
        wif.en = 1'b1; wif.addr = a; wif.val = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();

        // Reset state
        idle(); issue(1, 5'd5, 1, 5'd0, 0, 5'd0);
        push_exp("reset", 1, 32'h0, 1, 32'h0, 1, 0, 1, 0); tick();

        // Register write and read-back; reserve r3 first so the commit is not an underflow
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd3);
        push_exp("issue_r3", 0, 0, 0, 0, 1, 0, 0, 0); tick();
        idle(); commit(5'd3, 32'hDEADBEEF); rs1Addr = 5'd3;
        push_exp("wr3_same", 1, FWD ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0, 0, 0); tick();
        idle(); commit(5'd0, 32'h1234); rs1Addr = 5'd3; rs2Addr = 5'd0;
        push_exp("wr3_next", 1, 32'hDEADBEEF, 1, 32'h0, 0, 0, 0, 0); tick();
        idle(); rs1Addr = 5'd0; rs2Addr = 5'd3;
        push_exp("wr0_drop", 1, 32'h0, 1, 32'hDEADBEEF, 0, 0, 1, 0); tick();

        // RAW on r7
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd7);
        push_exp("issue_r7", 0, 0, 0, 0, 1, 0, 0, 0); tick();
        idle(); issue(1, 5'd7, 0, 5'd0, 0, 5'd0);
        push_exp("raw7_stall", 0, 0, 0, 0, 1, 1, 0, 0); tick();
        idle(); issue(1, 5'd7, 0, 5'd0, 0, 5'd0); commit(5'd7, 32'h55);
        push_exp("raw7_commit", 1, FWD ? 32'h55 : 32'h0, 0, 0, 1, FWD ? 1'b0 : 1'b1, 0, 0); tick();
        idle(); issue(1, 5'd7, 0, 5'd0, 0, 5'd0);
        push_exp("raw7_after", 1, 32'h55, 0, 0, 1, 0, 1, 0); tick();

        // Counter saturation on r4
        for (int i = 0; i < 3; i++) begin
            idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd4);
            push_exp("fill_r4", 0, 0, 0, 0, 1, 0, 0, 0); tick();
        end
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd4);
        push_exp("full_r4", 0, 0, 0, 0, 1, 1, 0, 0); tick();
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd4); commit(5'd4, 32'h44);
        push_exp("full_r4_commit", 0, 0, 0, 0, 1, 1, 0, 0); tick();
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd4);
        push_exp("r4_accept", 0, 0, 0, 0, 1, 0, 1, 0); tick();

        // Flush clears r9/r10, then an orphan commit to r9 underflows
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd9);
        push_exp("issue_r9", 0, 0, 0, 0, 1, 0, 0, 0); tick();
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd10);
        push_exp("issue_r10", 0, 0, 0, 0, 1, 0, 0, 0); tick();
        idle(); issue(1, 5'd9, 1, 5'd10, 0, 5'd0); flush = 1'b1;
        push_exp("pre_flush", 0, 0, 0, 0, 1, 1, 0, 0); tick();
        idle(); issue(1, 5'd9, 1, 5'd10, 0, 5'd0);
        push_exp("post_flush", 0, 0, 0, 0, 1, 0, 1, 0); tick();
        idle(); commit(5'd9, 32'h99);
        push_exp("orphan9", 0, 0, 0, 0, 0, 0, 1, 0); tick();
        idle(); rs1Addr = 5'd9;
        push_exp("underflow", 1, 32'h99, 0, 0, 0, 0, 1, 1); tick();
        for (int i = 0; i < 2; i++) begin
            idle();
            push_exp("underflow_sticky", 0, 0, 0, 0, 1, 0, 1, 1); tick();
        end

        // Simultaneous incr and decr on r6
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd6);
        push_exp("issue_r6", 0, 0, 0, 0, 1, 0, 0, 0); tick();
        idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd6); commit(5'd6, 32'h66);
        push_exp("r6_inc_dec", 0, 0, 0, 0, 1, 0, 0, 0); tick();
        idle(); issue(1, 5'd6, 0, 5'd0, 0, 5'd0);
        push_exp("r6_still_busy", 1, 32'h66, 0, 0, 1, 1, 0, 0); tick();
        idle(); commit(5'd6, 32'h67);
        push_exp("r6_commit2", 0, 0, 0, 0, 0, 0, 0, 0); tick();
        idle(); issue(1, 5'd6, 0, 5'd0, 0, 5'd0);
        push_exp("r6_free", 1, 32'h67, 0, 0, 1, 0, 1, 1); tick();

        // Reset clears everything including the sticky flag
        idle(); rst = 1'b1; tick();
        idle(); issue(1, 5'd3, 1, 5'd9, 0, 5'd0);
        push_exp("re_reset", 1, 32'h0, 1, 32'h0, 1, 0, 1, 0); tick();

        idle();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
